// File: rtl/fifo.sv
// Single-clock FIFO of 2**ADDR_BITS words. Pointers carry an extra wrap bit
// so that full and empty can both be decoded from the registered pointers.
module fifo #(
  parameter int WORD_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [WORD_BITS-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WORD_BITS-1:0] mem_r [DEPTH];
  logic [ADDR_BITS:0]   wptr_r;
  logic [ADDR_BITS:0]   rptr_r;
  logic [WORD_BITS-1:0] rdata_r;

  logic                 empty_s;
  logic                 full_s;
  logic                 rd_acc_s;
  logic                 wr_acc_s;
  logic [ADDR_BITS:0]   wptr_inc_s;
  logic [ADDR_BITS:0]   rptr_inc_s;

  // Flag decode and accept qualification from the registered pointers.
  always_comb begin
    empty_s    = 1'b0;
    full_s     = 1'b0;
    rd_acc_s   = 1'b0;
    wr_acc_s   = 1'b0;
    wptr_inc_s = wptr_r + {{ADDR_BITS{1'b0}}, 1'b1};
    rptr_inc_s = rptr_r + {{ADDR_BITS{1'b0}}, 1'b1};
    if (wptr_r == rptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if ((wptr_r[ADDR_BITS-1:0] == rptr_r[ADDR_BITS-1:0]) &&
        (wptr_r[ADDR_BITS] != rptr_r[ADDR_BITS])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    rd_acc_s = read_i & ~empty_s;
    wr_acc_s = write_i & (~full_s | rd_acc_s);
  end

  // Pointer and read-data registers; reset has priority over both requests.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wptr_r  <= {(ADDR_BITS+1){1'b0}};
      rptr_r  <= {(ADDR_BITS+1){1'b0}};
      rdata_r <= {WORD_BITS{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_inc_s;
      end else begin
        wptr_r <= wptr_r;
      end
      if (rd_acc_s) begin
        rptr_r  <= rptr_inc_s;
        rdata_r <= mem_r[rptr_r[ADDR_BITS-1:0]];
      end else begin
        rptr_r  <= rptr_r;
        rdata_r <= rdata_r;
      end
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i && wr_acc_s) begin
      mem_r[wptr_r[ADDR_BITS-1:0]] <= wdata_i;
    end
  end

  assign empty_o = empty_s;
  assign full_o  = full_s;
  assign rdata_o = rdata_r;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed plan followed by random traffic,
// compared against a queue-based reference model.
module tb_fifo;

  localparam int WB    = 8;
  localparam int AB    = 4;
  localparam int DEPTH = 2 ** AB;

  logic          clk_i   = 1'b0;
  logic          reset_i = 1'b0;
  logic          read_i  = 1'b0;
  logic          write_i = 1'b0;
  logic [WB-1:0] wdata_i = '0;
  logic          empty_o;
  logic          full_o;
  logic [WB-1:0] rdata_o;

  int vectors = 0;
  int errors  = 0;

  logic [WB-1:0] model_q[$];
  logic [WB-1:0] exp_rdata = '0;

  fifo #(.WORD_BITS(WB), .ADDR_BITS(AB)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .read_i  (read_i),
    .write_i (write_i),
    .wdata_i (wdata_i),
    .empty_o (empty_o),
    .full_o  (full_o),
    .rdata_o (rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check just after.
  task automatic step(input logic rst_n, input logic rd, input logic wr, input logic [WB-1:0] d);
    bit acc_rd;
    bit acc_wr;
    @(negedge clk_i);
    reset_i = rst_n;
    read_i  = rd;
    write_i = wr;
    wdata_i = d;
    @(posedge clk_i);
    if (!rst_n) begin
      model_q.delete();
      exp_rdata = '0;
    end else begin
      acc_rd = rd && (model_q.size() > 0);
      acc_wr = wr && ((model_q.size() < DEPTH) || acc_rd);
      if (acc_rd) exp_rdata = model_q.pop_front();
      if (acc_wr) model_q.push_back(d);
    end
    #1;
    chk("empty", {31'd0, empty_o}, {31'd0, model_q.size() == 0});
    chk("full",  {31'd0, full_o},  {31'd0, model_q.size() == DEPTH});
    chk("rdata", {24'd0, rdata_o}, {24'd0, exp_rdata});
  endtask

  initial begin
    // Reset held for two cycles.
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full",  {31'd0, full_o},  32'd0);
    chk("rst_rdata", {24'd0, rdata_o}, 32'd0);

    // Fill with 1..16, idle cycle after each write.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'(i));
      chk("fill_empty", {31'd0, empty_o}, 32'd0);
      chk("fill_full",  {31'd0, full_o},  (i == DEPTH) ? 32'd1 : 32'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
    end

    // Overflow write is dropped.
    step(1'b1, 1'b0, 1'b1, 8'd17);
    chk("ovf_full", {31'd0, full_o}, 32'd1);

    // Drain returns 1..16 only.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'd0);
      chk("drain_data", {24'd0, rdata_o}, 32'(i));
      chk("drain_full", {31'd0, full_o}, 32'd0);
    end
    chk("drain_empty", {31'd0, empty_o}, 32'd1);

    // Underflow read leaves rdata and flags alone.
    step(1'b1, 1'b1, 1'b0, 8'd0);
    chk("unf_rdata", {24'd0, rdata_o}, 32'd16);
    chk("unf_empty", {31'd0, empty_o}, 32'd1);

    // Simultaneous read+write on empty performs only the write.
    step(1'b1, 1'b1, 1'b1, 8'd1);
    chk("rw_empty_rdata", {24'd0, rdata_o}, 32'd16);
    chk("rw_empty_flag",  {31'd0, empty_o}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'd2);
    step(1'b1, 1'b0, 1'b1, 8'd3);

    // 40 concurrent cycles across pointer wraps; occupancy stays at 3.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'(i + 4));
      chk("conc_data", {24'd0, rdata_o}, 32'(i + 1));
    end
    chk("conc_occ", model_q.size(), 32'd3);

    // Fill up, then read+write together while full.
    for (int i = 0; i < DEPTH - 3; i++) step(1'b1, 1'b0, 1'b1, 8'(i + 44));
    chk("full_before", {31'd0, full_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'(i + 100));
      chk("full_rw_data", {24'd0, rdata_o}, 32'(i + 41));
      chk("full_rw_flag", {31'd0, full_o}, 32'd1);
    end

    // Reset mid-stream discards contents.
    step(1'b0, 1'b1, 1'b1, 8'd200);
    chk("midrst_empty", {31'd0, empty_o}, 32'd1);
    chk("midrst_rdata", {24'd0, rdata_o}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
